// File: rtl/seven_segment_reader.sv
// Seven-segment bus reader: debounces scanned digit/segment samples, decodes them to hex nibbles and publishes one word per frame.
// Define SEVEN_SEGMENT_READER_ACTIVE_LOW_EN to invert i_SEG and i_DIGIT_SEL for common-anode displays.
module seven_segment_reader #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                  i_CLK,
  input  logic                  i_RST_N,
  input  logic                  i_SAMPLE_EN,
  input  logic [DIGITS-1:0]     i_DIGIT_SEL,
  input  logic [7:0]            i_SEG,
  input  logic                  i_CLR_ERR,
  output logic [4*DIGITS-1:0]   o_DATA,
  output logic [DIGITS-1:0]     o_DP,
  output logic                  o_VALID,
  output logic                  o_ERR
);

  typedef enum logic [0:0] {
    ACQUIRE = 1'b0,
    PUBLISH = 1'b1
  } state_t;

  localparam logic [3:0]        CNT_MAX      = 4'(STABLE_CNT);
  localparam logic [DIGITS-1:0] ALL_CAPTURED = {DIGITS{1'b1}};

  logic [DIGITS-1:0] sel;
  logic [7:0]        seg;

`ifdef SEVEN_SEGMENT_READER_ACTIVE_LOW_EN
  assign sel = ~i_DIGIT_SEL;
  assign seg = ~i_SEG;
`else
  assign sel = i_DIGIT_SEL;
  assign seg = i_SEG;
`endif

  // Returns {valid, nibble}; anything outside the 16 hex glyphs is invalid.
  function automatic logic [4:0] decodeSeg(input logic [6:0] pattern);
    logic [4:0] result;
    case (pattern)
      7'b0111111: result = {1'b1, 4'h0};
      7'b0000110: result = {1'b1, 4'h1};
      7'b1011011: result = {1'b1, 4'h2};
      7'b1001111: result = {1'b1, 4'h3};
      7'b1100110: result = {1'b1, 4'h4};
      7'b1101101: result = {1'b1, 4'h5};
      7'b1111101: result = {1'b1, 4'h6};
      7'b0000111: result = {1'b1, 4'h7};
      7'b1111111: result = {1'b1, 4'h8};
      7'b1101111: result = {1'b1, 4'h9};
      7'b1110111: result = {1'b1, 4'hA};
      7'b1111100: result = {1'b1, 4'hB};
      7'b0111001: result = {1'b1, 4'hC};
      7'b1011110: result = {1'b1, 4'hD};
      7'b1111001: result = {1'b1, 4'hE};
      7'b1110001: result = {1'b1, 4'hF};
      default:    result = 5'b0_0000;
    endcase
    return result;
  endfunction

  state_t              state_q, state_d;
  logic [DIGITS-1:0]   heldSel_q, heldSel_d;
  logic [7:0]          heldSeg_q, heldSeg_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DIGITS-1:0]   captured_q, captured_d;
  logic [4*DIGITS-1:0] shadowData_q, shadowData_d;
  logic [DIGITS-1:0]   shadowDp_q, shadowDp_d;
  logic [4*DIGITS-1:0] data_q, data_d;
  logic [DIGITS-1:0]   dp_q, dp_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;

  logic                oneHot;
  logic                sameSample;
  logic                accept;
  logic [4:0]          decoded;

  // The accept pulse fires only on the sample that brings the run up to CNT_MAX.
  always_comb begin
    heldSel_d  = heldSel_q;
    heldSeg_d  = heldSeg_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    oneHot     = $onehot(sel);
    sameSample = ({sel, seg} == {heldSel_q, heldSeg_q});
    if (i_SAMPLE_EN) begin
      if (!oneHot) begin
        cnt_d = 4'd0;
      end else if (sameSample) begin
        if (cnt_q < CNT_MAX) begin
          cnt_d  = cnt_q + 4'd1;
          accept = (cnt_d == CNT_MAX);
        end
      end else begin
        heldSel_d = sel;
        heldSeg_d = seg;
        cnt_d     = 4'd1;
        accept    = (CNT_MAX == 4'd1);
      end
    end
  end

  // A digit accepted during PUBLISH keeps its captured bit across the clear.
  always_comb begin
    decoded      = decodeSeg(seg[6:0]);
    captured_d   = (state_q == PUBLISH) ? '0 : captured_q;
    shadowData_d = shadowData_q;
    shadowDp_d   = shadowDp_q;
    err_d        = i_CLR_ERR ? 1'b0 : err_q;
    if (accept) begin
      if (decoded[4]) begin
        for (int k = 0; k < DIGITS; k++) begin
          if (sel[k]) begin
            shadowData_d[4*k +: 4] = decoded[3:0];
            shadowDp_d[k]          = seg[7];
            captured_d[k]          = 1'b1;
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dp_d    = dp_q;
    valid_d = 1'b0;
    case (state_q)
      ACQUIRE: begin
        if (captured_q == ALL_CAPTURED) begin
          state_d = PUBLISH;
        end
      end
      PUBLISH: begin
        data_d  = shadowData_q;
        dp_d    = shadowDp_q;
        valid_d = 1'b1;
        state_d = ACQUIRE;
      end
      default: state_d = ACQUIRE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_q      <= ACQUIRE;
      heldSel_q    <= '0;
      heldSeg_q    <= '0;
      cnt_q        <= '0;
      captured_q   <= '0;
      shadowData_q <= '0;
      shadowDp_q   <= '0;
      data_q       <= '0;
      dp_q         <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      heldSel_q    <= heldSel_d;
      heldSeg_q    <= heldSeg_d;
      cnt_q        <= cnt_d;
      captured_q   <= captured_d;
      shadowData_q <= shadowData_d;
      shadowDp_q   <= shadowDp_d;
      data_q       <= data_d;
      dp_q         <= dp_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign o_DATA  = data_q;
  assign o_DP    = dp_q;
  assign o_VALID = valid_q;
  assign o_ERR   = err_q;

endmodule
